// File: rtl/rep_sequencer_if.sv
// Upstream/execute handshake bundle for the REP string-op issue controller.
// The master side is whoever owns the upstream latch and execute stall; the
// slave side is the sequencer itself.
interface rep_sequencer_if #(
   parameter int CNT_W = 32
);
   // upstream latch and execute-side inputs
   logic             valid_in;
   logic             is_rep_in;
   logic [CNT_W-1:0] ecx_in;
   logic             stall_in;
   logic             ie_pending;
   logic             flush;

   // issue / write-back outputs
   logic             issue_valid;
   logic             stall_up;
   logic [CNT_W-1:0] ecx_out;
   logic             ecx_wb;
   logic             last_iter;
   logic             rep_skip;
   logic             ie_ack;
   logic             rep_busy;

   modport master (
      output valid_in, is_rep_in, ecx_in, stall_in, ie_pending, flush,
      input  issue_valid, stall_up, ecx_out, ecx_wb, last_iter, rep_skip,
             ie_ack, rep_busy
   );

   modport slave (
      input  valid_in, is_rep_in, ecx_in, stall_in, ie_pending, flush,
      output issue_valid, stall_up, ecx_out, ecx_wb, last_iter, rep_skip,
             ie_ack, rep_busy
   );
endinterface

// File: rtl/rep_sequencer.sv
// REP string-op issue controller: holds a REP instruction in the upstream
// latch and replays it into execute once per iteration, writing back the
// decremented ECX each time and opening an interrupt window between
// iterations. Non-REP instructions pass through combinationally.
module rep_sequencer #(
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst,   // asynchronous, active-low
   rep_sequencer_if.slave    bus
);

   typedef enum logic {
      IDLE = 1'b0,
      ITER = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ie_ack_q, ie_ack_d;
   logic             is_last;

   assign is_last = (count_q == CNT_W'(1));

   // Next-state and combinational issue outputs; flush overrides everything.
   always_comb begin
      state_d         = state_q;
      count_d         = count_q;
      ie_ack_d        = 1'b0;
      bus.issue_valid = 1'b0;
      bus.stall_up    = 1'b0;
      bus.ecx_out     = '0;
      bus.ecx_wb      = 1'b0;
      bus.last_iter   = 1'b0;
      bus.rep_skip    = 1'b0;

      if (bus.flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.valid_in && !bus.is_rep_in) begin
                  bus.issue_valid = 1'b1;
               end else if (bus.valid_in && !ie_ack_q) begin
                  // While ie_ack is up the suspended REP still sits in the
                  // latch awaiting the interrupt redirect; it must not be
                  // restarted, so it is neither loaded nor held.
                  if (bus.stall_in) begin
                     bus.stall_up = 1'b1;
                  end else if (bus.ecx_in == '0) begin
                     bus.rep_skip = 1'b1;
                  end else begin
                     bus.stall_up = 1'b1;
                     count_d      = bus.ecx_in;
                     state_d      = ITER;
                  end
               end
            end
            ITER: begin
               bus.issue_valid = 1'b1;
               bus.ecx_out     = count_q - CNT_W'(1);
               bus.last_iter   = is_last;
               bus.ecx_wb      = !bus.stall_in;
               bus.stall_up    = 1'b1;
               if (!bus.stall_in) begin
                  count_d = count_q - CNT_W'(1);
                  if (is_last) begin
                     state_d      = IDLE;
                     bus.stall_up = 1'b0;
                  end else if (bus.ie_pending) begin
                     state_d  = IDLE;
                     ie_ack_d = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State, iteration count and registered interrupt acknowledge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         ie_ack_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         ie_ack_q <= ie_ack_d;
      end
   end

   assign bus.ie_ack   = ie_ack_q;
   assign bus.rep_busy = (state_q != IDLE);

endmodule

// File: tb/tb_rep_sequencer.sv
// Self-checking bench for rep_sequencer: directed scenarios followed by a
// randomized run checked against a queue-based model of pending iterations.
module tb_rep_sequencer;
   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   rep_sequencer_if #(.CNT_W(CNT_W)) bus ();

   rep_sequencer #(.CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic drive(input logic v, input logic r, input int e,
                        input logic s, input logic ie, input logic f);
      bus.valid_in   = v;
      bus.is_rep_in  = r;
      bus.ecx_in     = CNT_W'(e);
      bus.stall_in   = s;
      bus.ie_pending = ie;
      bus.flush      = f;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk); #1;
      checks++; if (bus.rep_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.rep_busy); end
      checks++; if (bus.ie_ack !== 1'b0) begin errors++; $display("FAIL reset_ie_ack got %b exp 0", bus.ie_ack); end
      checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue got %b exp 0", bus.issue_valid); end
      @(negedge clk);
      rst = 1'b1;
      drive(1, 0, 7, 0, 0, 0);
      #1;
      checks++; if (bus.issue_valid !== 1'b1) begin errors++; $display("FAIL passthru_issue got %b exp 1", bus.issue_valid); end
      checks++; if (bus.stall_up !== 1'b0) begin errors++; $display("FAIL passthru_stall_up got %b exp 0", bus.stall_up); end
      checks++; if (bus.rep_busy !== 1'b0) begin errors++; $display("FAIL passthru_busy got %b exp 0", bus.rep_busy); end
      $display("txn reset+passthrough done");
   endtask

   task automatic test_rep3;
      @(negedge clk); drive(1, 1, 3, 0, 0, 0); #1;
      checks++; if (bus.stall_up !== 1'b1 || bus.issue_valid !== 1'b0) begin errors++; $display("FAIL rep3_accept su=%b iv=%b exp su=1 iv=0", bus.stall_up, bus.issue_valid); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         checks++; if (bus.issue_valid !== 1'b1 || bus.ecx_wb !== 1'b1) begin errors++; $display("FAIL rep3_issue%0d iv=%b wb=%b exp 1 1", i, bus.issue_valid, bus.ecx_wb); end
         checks++; if (bus.ecx_out !== CNT_W'(2 - i)) begin errors++; $display("FAIL rep3_ecx%0d got %0d exp %0d", i, bus.ecx_out, 2 - i); end
         checks++; if (bus.last_iter !== (i == 2) || bus.stall_up !== (i != 2)) begin errors++; $display("FAIL rep3_last%0d last=%b su=%b exp %b %b", i, bus.last_iter, bus.stall_up, i == 2, i != 2); end
      end
      @(negedge clk); drive(0, 0, 0, 0, 0, 0); #1;
      checks++; if (bus.rep_busy !== 1'b0 || bus.issue_valid !== 1'b0) begin errors++; $display("FAIL rep3_end busy=%b iv=%b exp 0 0", bus.rep_busy, bus.issue_valid); end
      $display("txn rep ecx=3 done");
   endtask

   task automatic test_skip;
      @(negedge clk); drive(1, 1, 0, 0, 0, 0); #1;
      checks++; if (bus.rep_skip !== 1'b1 || bus.issue_valid !== 1'b0 || bus.stall_up !== 1'b0) begin errors++; $display("FAIL skip skip=%b iv=%b su=%b exp 1 0 0", bus.rep_skip, bus.issue_valid, bus.stall_up); end
      @(negedge clk); drive(0, 0, 0, 0, 0, 0); #1;
      checks++; if (bus.rep_skip !== 1'b0 || bus.rep_busy !== 1'b0) begin errors++; $display("FAIL skip_after skip=%b busy=%b exp 0 0", bus.rep_skip, bus.rep_busy); end
      $display("txn rep ecx=0 skip done");
   endtask

   task automatic test_stall;
      int n_issue;
      int stall_pat[6] = '{0, 1, 1, 0, 0, 0};
      int ecx_pat[6]   = '{3, 2, 2, 2, 1, 0};
      n_issue = 0;
      @(negedge clk); drive(1, 1, 4, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); bus.stall_in = stall_pat[i][0]; #1;
         if (bus.issue_valid === 1'b1) n_issue++;
         checks++; if (bus.ecx_out !== CNT_W'(ecx_pat[i]) || bus.ecx_wb !== !stall_pat[i][0]) begin errors++; $display("FAIL stall_cyc%0d ecx=%0d wb=%b exp %0d %b", i, bus.ecx_out, bus.ecx_wb, ecx_pat[i], !stall_pat[i][0]); end
      end
      checks++; if (n_issue != 6) begin errors++; $display("FAIL stall_issue_count got %0d exp 6", n_issue); end
      checks++; if (bus.last_iter !== 1'b1) begin errors++; $display("FAIL stall_last got %b exp 1", bus.last_iter); end
      @(negedge clk); drive(0, 0, 0, 0, 0, 0); #1;
      checks++; if (bus.rep_busy !== 1'b0) begin errors++; $display("FAIL stall_end busy=%b exp 0", bus.rep_busy); end
      $display("txn rep ecx=4 with stall done");
   endtask

   task automatic test_ie;
      @(negedge clk); drive(1, 1, 5, 0, 0, 0);
      @(negedge clk); #1;
      checks++; if (bus.ecx_out !== CNT_W'(4)) begin errors++; $display("FAIL ie_iter1 ecx=%0d exp 4", bus.ecx_out); end
      @(negedge clk); bus.ie_pending = 1'b1; #1;
      checks++; if (bus.ecx_out !== CNT_W'(3) || bus.ecx_wb !== 1'b1) begin errors++; $display("FAIL ie_iter2 ecx=%0d wb=%b exp 3 1", bus.ecx_out, bus.ecx_wb); end
      @(negedge clk); bus.ie_pending = 1'b0; #1;
      checks++; if (bus.ie_ack !== 1'b1 || bus.stall_up !== 1'b0 || bus.rep_busy !== 1'b0) begin errors++; $display("FAIL ie_ack ack=%b su=%b busy=%b exp 1 0 0", bus.ie_ack, bus.stall_up, bus.rep_busy); end
      @(negedge clk); drive(0, 0, 0, 0, 0, 0); #1;
      checks++; if (bus.ie_ack !== 1'b0) begin errors++; $display("FAIL ie_ack_pulse ack=%b exp 0", bus.ie_ack); end
      $display("txn rep ecx=5 interrupted done");
   endtask

   task automatic test_flush;
      @(negedge clk); drive(1, 1, 8, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); bus.flush = 1'b1; #1;
      checks++; if (bus.issue_valid !== 1'b0 || bus.ecx_wb !== 1'b0 || bus.stall_up !== 1'b0) begin errors++; $display("FAIL flush_cycle iv=%b wb=%b su=%b exp 0 0 0", bus.issue_valid, bus.ecx_wb, bus.stall_up); end
      @(negedge clk); drive(0, 0, 0, 0, 0, 0); #1;
      checks++; if (bus.rep_busy !== 1'b0 || bus.ie_ack !== 1'b0) begin errors++; $display("FAIL flush_after busy=%b ack=%b exp 0 0", bus.rep_busy, bus.ie_ack); end
      $display("txn rep ecx=8 flushed done");
   endtask

   task automatic test_rst_mid;
      @(negedge clk); drive(1, 1, 6, 0, 0, 0);
      @(negedge clk);
      @(negedge clk); #1;
      rst = 1'b0; #1;
      checks++; if (bus.rep_busy !== 1'b0 || bus.ecx_wb !== 1'b0 || bus.issue_valid !== 1'b0) begin errors++; $display("FAIL rst_mid busy=%b wb=%b iv=%b exp 0 0 0", bus.rep_busy, bus.ecx_wb, bus.issue_valid); end
      @(negedge clk); rst = 1'b1; drive(0, 0, 0, 0, 0, 0); #1;
      checks++; if (bus.rep_busy !== 1'b0) begin errors++; $display("FAIL rst_release busy=%b exp 0", bus.rep_busy); end
      $display("txn reset mid-run done");
   endtask

   task automatic test_full_count;
      int bad;
      int n;
      bad = 0;
      n   = 0;
      @(negedge clk); drive(1, 1, 255, 0, 0, 0);
      for (int i = 0; i < 255; i++) begin
         @(negedge clk); #1;
         if (bus.issue_valid === 1'b1) n++;
         if (bus.ecx_out !== CNT_W'(254 - i) || bus.last_iter !== (i == 254)) bad++;
      end
      checks++; if (bad != 0 || n != 255) begin errors++; $display("FAIL full_count bad_cycles=%0d issues=%0d exp 0 255", bad, n); end
      @(negedge clk); drive(0, 0, 0, 0, 0, 0); #1;
      checks++; if (bus.rep_busy !== 1'b0) begin errors++; $display("FAIL full_end busy=%b exp 0", bus.rep_busy); end
      $display("txn rep ecx=255 done");
   endtask

   // Model: queue of ECX values still to be written back; busy == queue non-empty.
   task automatic test_random;
      int          q[$];
      logic        m_ack, nxt_ack, hold;
      logic        e_iv, e_su, e_wb, e_last, e_skip, e_ack, e_busy;
      logic [CNT_W-1:0] e_ecx;
      logic        v, r, s, ie, f;
      int          e;
      m_ack = 1'b0;
      hold  = 1'b0;
      v = 0; r = 0; e = 0;
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         if (!hold) begin
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 1) == 1;
            e = $urandom_range(0, 4);
         end
         s  = ($urandom_range(0, 3) == 0);
         ie = ($urandom_range(0, 7) == 0);
         f  = ($urandom_range(0, 19) == 0);
         drive(v, r, e, s, ie, f);
         #1;
         e_iv = 0; e_su = 0; e_wb = 0; e_last = 0; e_skip = 0; e_ecx = '0;
         e_ack = m_ack; e_busy = (q.size() != 0); nxt_ack = 1'b0;
         if (f) begin
            q.delete();
         end else if (q.size() == 0) begin
            if (v && !r) e_iv = 1;
            else if (v && r && !m_ack) begin
               if (s) e_su = 1;
               else if (e == 0) e_skip = 1;
               else begin
                  e_su = 1;
                  for (int k = e - 1; k >= 0; k--) q.push_back(k);
               end
            end
         end else begin
            e_iv   = 1;
            e_ecx  = CNT_W'(q[0]);
            e_last = (q.size() == 1);
            e_wb   = !s;
            e_su   = !(!s && q.size() == 1);
            if (!s) begin
               void'(q.pop_front());
               if (q.size() != 0 && ie) begin
                  q.delete();
                  nxt_ack = 1'b1;
               end
            end
         end
         m_ack = nxt_ack;
         hold  = e_su;
         checks++;
         if (bus.issue_valid !== e_iv || bus.stall_up !== e_su || bus.ecx_wb !== e_wb ||
             bus.last_iter !== e_last || bus.rep_skip !== e_skip || bus.ie_ack !== e_ack ||
             bus.rep_busy !== e_busy || (e_iv && e_busy && bus.ecx_out !== e_ecx)) begin
            errors++;
            $display("FAIL rand_cyc%0d got iv%b su%b wb%b last%b skip%b ack%b busy%b ecx%0d exp iv%b su%b wb%b last%b skip%b ack%b busy%b ecx%0d",
                     c, bus.issue_valid, bus.stall_up, bus.ecx_wb, bus.last_iter, bus.rep_skip, bus.ie_ack, bus.rep_busy, bus.ecx_out,
                     e_iv, e_su, e_wb, e_last, e_skip, e_ack, e_busy, e_ecx);
         end
      end
      $display("txn random run of 800 cycles done");
   endtask

   initial begin
      test_reset();
      test_rep3();
      test_skip();
      test_stall();
      test_ie();
      test_flush();
      test_rst_mid();
      test_full_count();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
